// File: rtl/load_seq_pkg.sv
// load_seq_pkg: shared state encoding, slot count and counter widths for load_sequencer
package load_seq_pkg;
  localparam int SLOTS = 8;
  localparam int SLOT_W = 3;
  localparam int PHASE_W = 3;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/load_sequencer_if.sv
// load_sequencer_if: source handshake and datapath load bus; frame_parity exists only with LOAD_SEQ_PARITY_EN
interface load_sequencer_if #(parameter int DATA_W = 4);
  import load_seq_pkg::*;
  logic enable;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] arch_data;
  logic [SLOT_W-1:0] arch_slot;
  logic arch_load;
  logic [PHASE_W-1:0] arch_phase;
  logic busy;
  logic frame_done;
`ifdef LOAD_SEQ_PARITY_EN
  logic frame_parity;
  modport master(output enable, data_in, in_valid,
                 input in_ready, arch_data, arch_slot, arch_load, arch_phase, busy, frame_done, frame_parity);
  modport slave(input enable, data_in, in_valid,
                output in_ready, arch_data, arch_slot, arch_load, arch_phase, busy, frame_done, frame_parity);
`else
  modport master(output enable, data_in, in_valid,
                 input in_ready, arch_data, arch_slot, arch_load, arch_phase, busy, frame_done);
  modport slave(input enable, data_in, in_valid,
                output in_ready, arch_data, arch_slot, arch_load, arch_phase, busy, frame_done);
`endif
endinterface

// File: rtl/mod8_counter.sv
// mod8_counter: 3-bit counter with clear, increment-enable and wrap to 0 after a programmable limit
module mod8_counter
  import load_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [SLOT_W-1:0] limit,
  output logic [SLOT_W-1:0] count,
  output logic              wrap
);
  logic [SLOT_W-1:0] count_q, count_d;
  always_comb begin
    wrap = inc && count_q == limit;
    count_d = (clr || wrap) ? '0 : inc ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: loads 8 nibbles per frame into slots 0..7, runs RUN_LEN phases, pulses frame_done; LOAD_SEQ_PARITY_EN adds frame_parity
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RUN_LEN = 8
) (
  input logic clk,
  input logic rst_n,
  load_sequencer_if.slave bus
);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(RUN_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  state_t state_q, state_d;
  logic [SLOT_W-1:0] slot, phase;
  logic slot_wrap, phase_wrap, in_ready, accept, in_run;
  logic [DATA_W-1:0] arch_data_q, arch_data_d;
  logic [SLOT_W-1:0] arch_slot_q, arch_slot_d;
  logic arch_load_q, arch_load_d;
  always_comb begin
    in_run = state_q == RUN;
    in_ready = state_q == LOAD && bus.enable;
    accept = in_ready && bus.in_valid;
    state_d = state_q == IDLE ? (bus.enable ? LOAD : IDLE)
            : state_q == LOAD ? (slot_wrap ? RUN : LOAD)
            : state_q == RUN  ? (phase_wrap ? DONE : RUN)
            : (bus.enable ? LOAD : IDLE);
    arch_load_d = accept;
    arch_data_d = accept ? bus.data_in : arch_data_q;
    arch_slot_d = accept ? slot : arch_slot_q;
  end
  mod8_counter u_slot (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(accept),
    .limit(SLOT_LAST), .count(slot), .wrap(slot_wrap)
  );
  // phase is held at 0 outside RUN so arch_phase needs no extra gating
  mod8_counter u_phase (
    .clk(clk), .rst_n(rst_n), .clr(!in_run), .inc(in_run),
    .limit(PH_LAST), .count(phase), .wrap(phase_wrap)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      arch_load_q <= 1'b0;
      arch_data_q <= '0;
      arch_slot_q <= '0;
    end else begin
      state_q <= state_d;
      arch_load_q <= arch_load_d;
      arch_data_q <= arch_data_d;
      arch_slot_q <= arch_slot_d;
    end
`ifdef LOAD_SEQ_PARITY_EN
  logic parity_q, parity_d;
  // slot 0 restarts the accumulator, so the previous frame's value stays visible through DONE
  always_comb parity_d = accept ? (^bus.data_in) ^ (slot == '0 ? 1'b0 : parity_q) : parity_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity_q <= 1'b0;
    else parity_q <= parity_d;
  assign bus.frame_parity = parity_q;
`endif
  assign bus.in_ready = in_ready;
  assign bus.arch_load = arch_load_q;
  assign bus.arch_data = arch_data_q;
  assign bus.arch_slot = arch_slot_q;
  assign bus.arch_phase = phase;
  assign bus.busy = state_q != IDLE;
  assign bus.frame_done = state_q == DONE;
endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer: directed frames with a scoreboard queue of expected strobes checked by a negedge monitor
module tb_load_sequencer;
  import load_seq_pkg::*;
  localparam int RL = 8;
  typedef struct {
    logic [2:0] slot;
    logic [3:0] data;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  beat_t sb[$];
  logic [2:0] slot_exp = '0;
  logic par_exp = 1'b0;
  int rp = -1;
  bit exp_done = 1'b0;
  load_sequencer_if #(.DATA_W(4)) dif ();
  load_sequencer #(.DATA_W(4), .RUN_LEN(RL)) dut (.clk(clk), .rst_n(rst_n), .bus(dif.slave));
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endfunction

  task automatic send(input logic [3:0] d);
    int n = 0;
    dif.in_valid = 1'b1;
    dif.data_in = d;
    do begin
      @(negedge clk);
      n++;
    end while (!dif.in_ready && n < 50);
    if (!dif.in_ready) timeout("accept");
    else begin
      sb.push_back('{slot_exp, d});
      par_exp = (slot_exp == 3'd0 ? 1'b0 : par_exp) ^ (^d);
      slot_exp++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!dif.frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!dif.frame_done) timeout("frame_done");
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      rp = -1;
      exp_done = 1'b0;
    end else begin
      if (dif.arch_load) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL strobe: unexpected arch_load slot %0d data %0h at %0t", dif.arch_slot, dif.arch_data, $time);
        end else begin
          e = sb.pop_front();
          chk("arch_slot", int'(dif.arch_slot), int'(e.slot));
          chk("arch_data", int'(dif.arch_data), int'(e.data));
          if (e.slot == 3'd7) rp = 0;
        end
      end
      if (rp >= 0) begin
        chk("arch_phase", int'(dif.arch_phase), rp);
        chk("frame_done_run", int'(dif.frame_done), 0);
        rp++;
        if (rp == RL) begin
          rp = -1;
          exp_done = 1'b1;
        end
      end else if (exp_done) begin
        chk("frame_done", int'(dif.frame_done), 1);
`ifdef LOAD_SEQ_PARITY_EN
        chk("frame_parity", int'(dif.frame_parity), int'(par_exp));
`endif
        exp_done = 1'b0;
      end else begin
        chk("frame_done_idle", int'(dif.frame_done), 0);
        chk("arch_phase_idle", int'(dif.arch_phase), 0);
      end
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_load"}, int'(dif.arch_load), 0);
    chk({tag, "_slot"}, int'(dif.arch_slot), 0);
    chk({tag, "_data"}, int'(dif.arch_data), 0);
    chk({tag, "_phase"}, int'(dif.arch_phase), 0);
    chk({tag, "_busy"}, int'(dif.busy), 0);
    chk({tag, "_done"}, int'(dif.frame_done), 0);
    chk({tag, "_ready"}, int'(dif.in_ready), 0);
  endtask

  initial begin
    int n;
    dif.enable = 1'b0;
    dif.in_valid = 1'b0;
    dif.data_in = '0;
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", int'(dif.busy), 0);
      chk("idle_ready", int'(dif.in_ready), 0);
    end
    @(posedge clk);
    #1 dif.enable = 1'b1;
    for (int i = 1; i <= 8; i++) send(4'(i));
    dif.in_valid = 1'b0;
    wait_done();
    @(posedge clk);
    #1;
    chk("reload_busy", int'(dif.busy), 1);
    chk("reload_ready", int'(dif.in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      send(4'(i * 3 + 2));
      dif.in_valid = 1'b0;
      dif.data_in = 4'hF;
      @(posedge clk);
      #1;
    end
    wait_done();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(4'(10 + i));
    dif.enable = 1'b0;
    dif.in_valid = 1'b1;
    dif.data_in = 4'hE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_ready", int'(dif.in_ready), 0);
      chk("pause_busy", int'(dif.busy), 1);
    end
    @(posedge clk);
    #1 dif.enable = 1'b1;
    for (int i = 0; i < 4; i++) send(4'(14 + i));
    dif.enable = 1'b0;
    dif.in_valid = 1'b0;
    wait_done();
    @(posedge clk);
    #1;
    chk("run_exit_idle", int'(dif.busy), 0);
    @(posedge clk);
    #1 dif.enable = 1'b1;
    for (int i = 0; i < 5; i++) send(4'(i + 3));
    dif.in_valid = 1'b1;
    dif.data_in = 4'h9;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    sb.delete();
    slot_exp = '0;
    dif.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'hF);
    send(4'h1);
    for (int i = 0; i < 6; i++) send(4'h0);
    dif.enable = 1'b0;
    dif.in_valid = 1'b0;
    wait_done();
    n = 0;
    while ((sb.size() != 0 || rp >= 0 || exp_done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter: DATA_W, default 4, width of each loaded nibble and of arch_data.
REQ-002 Parameter: RUN_LEN, default 8, number of RUN cycles per frame; legal range 1..8.
REQ-003 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: enable  input  1  frame start and load permission.
REQ-006 Port: data_in  input  DATA_W  nibble offered by the source.
REQ-007 Port: in_valid  input  1  data_in valid.
REQ-008 Port: in_ready  output  1  sequencer accepts data_in this cycle.
REQ-009 Port: arch_data  output  DATA_W  registered nibble to the datapath.
REQ-010 Port: arch_slot  output  3  slot index 0..7 of arch_data.
REQ-011 Port: arch_load  output  1  one-cycle write strobe for arch_data/arch_slot.
REQ-012 Port: arch_phase  output  3  datapath phase count, valid during RUN.
REQ-013 Port: busy  output  1  high in LOAD, RUN and DONE.
REQ-014 Port: frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-016 IDLE SHALL go to LOAD on enable=1; otherwise it SHALL stay in IDLE.
REQ-017 in_ready SHALL be 1 only in LOAD with enable=1, and SHALL be combinational from state and enable.
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1; data_in with in_valid=0 SHALL be ignored.
REQ-019 Each accepted beat SHALL be presented on the next cycle as arch_data=data_in, arch_slot=slot and arch_load=1, then slot SHALL increment by 1.
REQ-020 arch_load SHALL be 0 in every cycle without a preceding accepted beat.
REQ-021 In LOAD, enable=0 SHALL pause the frame: in_ready=0, slot held, state held; loading resumes when enable returns to 1.
REQ-022 Acceptance of slot 7 SHALL move the FSM to RUN; slot SHALL wrap to 0.
REQ-023 RUN SHALL last exactly RUN_LEN cycles, with arch_phase counting 0..RUN_LEN-1, and SHALL ignore enable.
REQ-024 Outside RUN, arch_phase SHALL be 0.
REQ-025 DONE SHALL last one cycle with frame_done=1, then go to LOAD if enable=1, else to IDLE.
REQ-026 Every frame SHALL contain exactly 8 arch_load strobes, one per slot, in order 0..7.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, slot=0, arch_data=0, arch_slot=0, arch_load=0, arch_phase=0, busy=0 and frame_done=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no frame_done SHALL follow.
REQ-029 rst_n release SHALL be synchronised externally; the first active edge after release sees IDLE.

Configuration
REQ-030 With macro LOAD_SEQ_PARITY_EN defined, the block SHALL add output frame_parity, 1 bit, equal to the XOR of all 8 nibbles accepted in the frame.
REQ-031 frame_parity SHALL be valid while frame_done=1 and SHALL be cleared when the first beat of the next frame is accepted.
REQ-032 Without LOAD_SEQ_PARITY_EN, the port and its accumulator SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package load_seq_pkg SHALL hold the state enum, the constant SLOTS=8 and the slot/phase widths.
REQ-034 The slot and phase counters SHALL each be an instance of one sub-module, mod8_counter (clear, increment-enable, wrap at 7 or a programmable limit).

Verification
REQ-035 Reset, then enable=1 with 8 back-to-back valid beats 0x1..0x8 -> arch_load strobes with slots 0..7 carrying data 0x1..0x8; RUN of 8 cycles; frame_done one cycle later.
REQ-036 in_valid toggling every other cycle -> only valid beats are loaded; slot order is contiguous with no gaps or duplicates.
REQ-037 enable dropped after slot 3 for 5 cycles -> in_ready=0 and no strobes for those 5 cycles; resumes at slot 4.
REQ-038 enable dropped during RUN -> RUN completes all RUN_LEN cycles, frame_done pulses, FSM goes to IDLE.
REQ-039 rst_n asserted asynchronously at slot 5 -> outputs zero before the next edge; no frame_done; next frame starts at slot 0.
REQ-040 With LOAD_SEQ_PARITY_EN defined and nibbles 0xF,0x1,0,0,0,0,0,0 -> frame_parity=1 while frame_done=1.
